// File: rtl/floppy_dsk_arbiter_pkg.sv
// Shared definitions for the floppy disk-image fetch arbiter:
// FSM state encodings, channel indices, default widths and the fill byte.
package floppy_dsk_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } dsk_state_e;

  localparam logic CH_INT = 1'b0;
  localparam logic CH_EXT = 1'b1;

  localparam int DSK_AW_DEF = 22;
  localparam int MEM_AW_DEF = 24;

  // Byte returned to a drive when its fetch is abandoned.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Saturating increment for the 8-bit request timer.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/floppy_dsk_arbiter_dsk_rr_pick.sv
// dsk_rr_pick: two-way combinational grant between the internal and
// external drive channels.
// Configuration macro DSK_ROUND_ROBIN_EN: when defined, a tie goes to the
// channel that did not win last time; otherwise the internal drive always
// wins a tie.
module dsk_rr_pick
  import floppy_dsk_arbiter_pkg::*;
(
  input  logic [1:0] pending_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_o
);

`ifndef DSK_ROUND_ROBIN_EN
  // Fixed priority keeps the last-grant history only for observability.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Pick the single pending channel, or resolve a tie.
  always_comb begin
    any_o   = |pending_i;
    grant_o = CH_INT;
    if (pending_i == 2'b10) begin
      grant_o = CH_EXT;
    end else if (pending_i == 2'b11) begin
`ifdef DSK_ROUND_ROBIN_EN
      grant_o = ~last_grant_i;
`else
      grant_o = CH_INT;
`endif
    end
  end

endmodule

// File: rtl/floppy_dsk_arbiter.sv
// floppy_dsk_arbiter: shares one disk-image memory read port between the
// internal and external floppy byte fetchers. A change of a drive's read
// address requests a byte; the byte is fetched over a level req/ack
// handshake and returned on dskReadData with a one-cycle per-drive ack.
// Configuration macro DSK_ROUND_ROBIN_EN selects alternating tie-break
// (resolved inside dsk_rr_pick); undefined gives fixed internal priority.
module floppy_dsk_arbiter
  import floppy_dsk_arbiter_pkg::*;
#(
  parameter int                 DSK_AW   = DSK_AW_DEF,
  parameter int                 MEM_AW   = MEM_AW_DEF,
  parameter logic [MEM_AW-1:0]  INT_BASE = 24'h000000,
  parameter logic [MEM_AW-1:0]  EXT_BASE = 24'h400000,
  parameter int unsigned        TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              cen,
  input  logic [1:0]        chanEnable,
  input  logic [DSK_AW-1:0] dskReadAddrInt,
  input  logic [DSK_AW-1:0] dskReadAddrExt,
  output logic              dskReadAckInt,
  output logic              dskReadAckExt,
  output logic [7:0]        dskReadData,
  output logic              memReq,
  output logic [MEM_AW-1:0] memAddr,
  input  logic              memAck,
  input  logic [7:0]        memData,
  output logic              timeoutErr
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  dsk_state_e        state_q, state_d;
  logic [1:0]        valid_q, valid_d;
  logic [DSK_AW-1:0] last_addr_q [2];
  logic [DSK_AW-1:0] last_addr_d [2];
  logic              last_grant_q, last_grant_d;
  logic              chan_q, chan_d;
  logic              req_q, req_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        ack_q, ack_d;
  logic [7:0]        data_q, data_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        timer_q, timer_d;

  logic [DSK_AW-1:0] addr_c [2];
  logic [1:0]        pending;
  logic              grant;
  logic              any_pending;
  logic [7:0]        timer_inc;

  assign addr_c[0] = dskReadAddrInt;
  assign addr_c[1] = dskReadAddrExt;

  // A channel wants a byte when enabled and its address is new or unfetched.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      pending[c] = chanEnable[c] & (~valid_q[c] | (addr_c[c] != last_addr_q[c]));
    end
  end

  dsk_rr_pick u_pick (
    .pending_i    (pending),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_o        (any_pending)
  );

  assign timer_inc = sat_inc8(timer_q);

  // Next-state logic for the fetch FSM and all per-channel bookkeeping.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    last_addr_d  = last_addr_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    req_d        = req_q;
    addr_d       = addr_q;
    ack_d        = ack_q;
    data_d       = data_q;
    tmo_d        = tmo_q;
    timer_d      = timer_q;
    if (cen) begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_pending) begin
            chan_d              = grant;
            last_grant_d        = grant;
            last_addr_d[grant]  = addr_c[grant];
            addr_d              = (grant ? EXT_BASE : INT_BASE) + MEM_AW'(addr_c[grant]);
            req_d               = 1'b1;
            timer_d             = 8'd0;
            state_d             = ST_REQ;
          end
        end
        ST_REQ: begin
          if (memAck) begin
            data_d          = memData;
            ack_d[chan_q]   = chanEnable[chan_q];
            valid_d[chan_q] = 1'b1;
            req_d           = 1'b0;
            state_d         = ST_ACK;
          end else if (timer_inc == TMO_LIM) begin
            // Memory never answered: hand back the fill byte and flag it.
            data_d          = FILL_BYTE;
            ack_d[chan_q]   = chanEnable[chan_q];
            valid_d[chan_q] = 1'b1;
            tmo_d           = 1'b1;
            req_d           = 1'b0;
            timer_d         = timer_inc;
            state_d         = ST_ACK;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_ACK: begin
          ack_d   = 2'b00;
          tmo_d   = 1'b0;
          state_d = memAck ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          // Wait out a late or still-held ack before the next request.
          if (!memAck) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // Disabling a drive forgets what it had, including an in-flight result.
      valid_d = valid_d & chanEnable;
    end
  end

  // State registers; an async reset abandons any request immediately.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q        <= ST_IDLE;
      valid_q        <= 2'b00;
      last_addr_q[0] <= '0;
      last_addr_q[1] <= '0;
      last_grant_q   <= CH_EXT;
      chan_q         <= CH_INT;
      req_q          <= 1'b0;
      addr_q         <= '0;
      ack_q          <= 2'b00;
      data_q         <= 8'h00;
      tmo_q          <= 1'b0;
      timer_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      last_addr_q    <= last_addr_d;
      last_grant_q   <= last_grant_d;
      chan_q         <= chan_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      ack_q          <= ack_d;
      data_q         <= data_d;
      tmo_q          <= tmo_d;
      timer_q        <= timer_d;
    end
  end

  assign dskReadAckInt = ack_q[CH_INT];
  assign dskReadAckExt = ack_q[CH_EXT];
  assign dskReadData   = data_q;
  assign memReq        = req_q;
  assign memAddr       = addr_q;
  assign timeoutErr    = tmo_q;

endmodule

// File: tb/tb_floppy_dsk_arbiter.sv
// Directed bench for floppy_dsk_arbiter: the bench plays the memory side
// by hand and checks addresses, acks, data and timeout behaviour.
module tb_floppy_dsk_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [1:0]  chanEnable;
  logic [21:0] addrInt, addrExt;
  logic        ackInt, ackExt;
  logic [7:0]  rdData;
  logic        memReq;
  logic [23:0] memAddr;
  logic        memAck;
  logic [7:0]  memData;
  logic        timeoutErr;

  int n_cmp = 0;
  int n_bad = 0;

  int         ack_int_n = 0;
  int         ack_ext_n = 0;
  int         tmo_n     = 0;
  int         req_n     = 0;
  logic       req_prev  = 1'b0;
  logic [7:0] ack_data  = 8'h00;

  always #5 clk = ~clk;

  floppy_dsk_arbiter dut (
    .clk            (clk),
    ._reset         (rst_n),
    .cen            (cen),
    .chanEnable     (chanEnable),
    .dskReadAddrInt (addrInt),
    .dskReadAddrExt (addrExt),
    .dskReadAckInt  (ackInt),
    .dskReadAckExt  (ackExt),
    .dskReadData    (rdData),
    .memReq         (memReq),
    .memAddr        (memAddr),
    .memAck         (memAck),
    .memData        (memData),
    .timeoutErr     (timeoutErr)
  );

  // Count ack/timeout pulses and memReq rising edges away from the clock edge.
  always @(negedge clk) begin
    if (ackInt === 1'b1) begin
      ack_int_n <= ack_int_n + 1;
      ack_data  <= rdData;
    end
    if (ackExt === 1'b1) begin
      ack_ext_n <= ack_ext_n + 1;
      ack_data  <= rdData;
    end
    if (timeoutErr === 1'b1) tmo_n <= tmo_n + 1;
    if (memReq === 1'b1 && req_prev !== 1'b1) req_n <= req_n + 1;
    req_prev <= memReq;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Answer one memory request: wait for memReq, ack after dly cycles with d,
  // release the ack once memReq has dropped.
  task automatic serve(input string tag, input int dly, input logic [7:0] d,
                       output logic [23:0] a);
    int n;
    n = 0;
    while (memReq !== 1'b1 && n < 50) begin tick; n++; end
    check_val({tag, "_req_seen"}, {31'd0, memReq}, 32'd1);
    a = memAddr;
    repeat (dly) tick;
    memData = d;
    memAck  = 1'b1;
    n = 0;
    while (memReq !== 1'b0 && n < 50) begin tick; n++; end
    check_val({tag, "_req_drop"}, {31'd0, memReq}, 32'd0);
    memAck = 1'b0;
  endtask

  logic [23:0] a;
  logic [23:0] exp_a;
  logic        exp_w;
  int          base, r, cnt, n;

  initial begin
    rst_n = 1'b0; cen = 1'b1; chanEnable = 2'b00;
    addrInt = '0; addrExt = '0; memAck = 1'b0; memData = 8'h00;
    repeat (3) tick;
    check_val("rst_memReq", {31'd0, memReq}, 32'd0);
    check_val("rst_ackInt", {31'd0, ackInt}, 32'd0);
    check_val("rst_ackExt", {31'd0, ackExt}, 32'd0);
    check_val("rst_data",   {24'd0, rdData}, 32'd0);
    check_val("rst_tmo",    {31'd0, timeoutErr}, 32'd0);
    check_val("rst_addr",   {8'd0, memAddr}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single internal fetch, one-cycle request latency.
    chanEnable = 2'b01; addrInt = 22'h000010;
    tick;
    check_val("t1_latency", {31'd0, memReq}, 32'd1);
    serve("t1", 3, 8'hA5, a);
    check_val("t1_addr", {8'd0, a}, 32'h000010);
    repeat (3) tick;
    check_val("t1_ackInt_cnt", ack_int_n, 1);
    check_val("t1_ackExt_cnt", ack_ext_n, 0);
    check_val("t1_ack_data",   {24'd0, ack_data}, 32'hA5);
    check_val("t1_data_hold",  {24'd0, rdData}, 32'hA5);

    // External fetch with base offset; a held address is not re-fetched.
    chanEnable = 2'b11; addrExt = 22'h000020;
    serve("t2", 2, 8'h5A, a);
    check_val("t2_addr", {8'd0, a}, 32'h400020);
    repeat (3) tick;
    check_val("t2_ackExt_cnt", ack_ext_n, 1);
    check_val("t2_ackInt_cnt", ack_int_n, 1);
    check_val("t2_ack_data",   {24'd0, ack_data}, 32'h5A);
    r = req_n;
    repeat (10) tick;
    check_val("t2_no_refetch", req_n, r);

    // Ties: the winner's address moves on after each fetch so both stay pending.
    addrInt = 22'h000050; addrExt = 22'h000060;
    for (int k = 0; k < 4; k++) begin
`ifdef DSK_ROUND_ROBIN_EN
      exp_w = (k % 2) == 1;
`else
      exp_w = 1'b0;
`endif
      exp_a = exp_w ? (24'h400000 + {2'b00, addrExt}) : {2'b00, addrInt};
      serve("t3", 1, 8'(8'h10 + k), a);
      check_val($sformatf("t3_grant%0d", k), {8'd0, a}, {8'd0, exp_a});
      if (k < 3) begin
        if (exp_w) addrExt = addrExt + 22'd1;
        else       addrInt = addrInt + 22'd1;
      end
    end
    serve("t3_tail", 1, 8'h20, a);
`ifdef DSK_ROUND_ROBIN_EN
    check_val("t3_tail_addr", {8'd0, a}, 32'h000052);
`else
    check_val("t3_tail_addr", {8'd0, a}, 32'h400060);
`endif
    repeat (3) tick;

    // Timeout: no ack, fill byte returned, late ack holds the FSM off.
    chanEnable = 2'b01;
    tick;
    base = ack_int_n; r = tmo_n;
    addrInt = 22'h000070;
    n = 0;
    while (memReq !== 1'b1 && n < 20) begin tick; n++; end
    cnt = 0;
    while (memReq === 1'b1 && cnt < 400) begin cnt++; tick; end
    memAck = 1'b1;
    check_val("t4_req_len", cnt, 255);
    repeat (2) tick;
    check_val("t4_tmo_cnt",  tmo_n - r, 1);
    check_val("t4_ack_cnt",  ack_int_n - base, 1);
    check_val("t4_fill",     {24'd0, ack_data}, 32'hFF);
    addrInt = 22'h000071;
    r = req_n;
    repeat (6) tick;
    check_val("t4_drain_hold", req_n, r);
    memAck = 1'b0;
    serve("t4_after", 1, 8'hC3, a);
    check_val("t4_after_addr", {8'd0, a}, 32'h000071);
    repeat (2) tick;

    // Address changes while its fetch is in flight.
    addrInt = 22'h000080;
    tick;
    check_val("t5_req", {31'd0, memReq}, 32'd1);
    addrInt = 22'h000081;
    serve("t5a", 2, 8'h3C, a);
    check_val("t5a_addr", {8'd0, a}, 32'h000080);
    repeat (2) tick;
    check_val("t5a_data", {24'd0, ack_data}, 32'h3C);
    serve("t5b", 1, 8'h3D, a);
    check_val("t5b_addr", {8'd0, a}, 32'h000081);
    repeat (2) tick;
    check_val("t5b_data", {24'd0, ack_data}, 32'h3D);

    // Channel disabled mid-fetch: no ack, data still updates, refetch later.
    addrInt = 22'h0000A0;
    tick;
    check_val("t6_req", {31'd0, memReq}, 32'd1);
    chanEnable = 2'b00;
    base = ack_int_n;
    serve("t6", 1, 8'h77, a);
    repeat (3) tick;
    check_val("t6_no_ack", ack_int_n, base);
    check_val("t6_data",   {24'd0, rdData}, 32'h77);
    chanEnable = 2'b01;
    serve("t6_re", 1, 8'h78, a);
    check_val("t6_re_addr", {8'd0, a}, 32'h0000A0);
    repeat (2) tick;

    // Asynchronous reset while requesting with the clock enable low.
    addrInt = 22'h0000B0;
    tick;
    check_val("t7_req", {31'd0, memReq}, 32'd1);
    cen = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check_val("t7_rst_req",    {31'd0, memReq}, 32'd0);
    check_val("t7_rst_ackInt", {31'd0, ackInt}, 32'd0);
    check_val("t7_rst_ackExt", {31'd0, ackExt}, 32'd0);
    tick;
    rst_n = 1'b1; cen = 1'b1;
    serve("t7_re", 1, 8'h99, a);
    check_val("t7_re_addr", {8'd0, a}, 32'h0000B0);
    repeat (2) tick;
    check_val("t7_re_data", {24'd0, ack_data}, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
